// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one FP op to the pipelined FP ALU, holds its inputs for the op latency, then captures result/flags.
module fpu_issue_ctrl #(
    parameter int LAT_ADDSUB = 7,
    parameter int LAT_MUL    = 5,
    parameter int LAT_DIV    = 6,
    parameter int LAT_SQRT   = 16,
    parameter int LAT_CMP    = 1,
    parameter int LAT_CVT    = 6,
    parameter int LAT_COMB   = 0
) (
    input  logic        iclock,
    input  logic        ireset,
    input  logic        istart,
    input  logic [3:0]  iop,
    input  logic [31:0] ia,
    input  logic [31:0] ib,
    output logic        obusy,
    output logic        odone,
    output logic        oillegal,
    output logic [31:0] oresult,
    output logic        onan,
    output logic        ozero,
    output logic        ooverflow,
    output logic        ounderflow,
    output logic        ocompresult,
    output logic [3:0]  ofpu_control,
    output logic [31:0] ofpu_dataa,
    output logic [31:0] ofpu_datab,
    input  logic [31:0] ifpu_result,
    input  logic        ifpu_nan,
    input  logic        ifpu_zero,
    input  logic        ifpu_overflow,
    input  logic        ifpu_underflow,
    input  logic        ifpu_compresult
);
    localparam logic [3:0] OPADDS  = 4'd0;
    localparam logic [3:0] OPSUBS  = 4'd1;
    localparam logic [3:0] OPMULS  = 4'd2;
    localparam logic [3:0] OPDIVS  = 4'd3;
    localparam logic [3:0] OPSQRT  = 4'd4;
    localparam logic [3:0] OPABS   = 4'd5;
    localparam logic [3:0] OPNEG   = 4'd6;
    localparam logic [3:0] OPCEQ   = 4'd7;
    localparam logic [3:0] OPCLT   = 4'd8;
    localparam logic [3:0] OPCLE   = 4'd9;
    localparam logic [3:0] OPCVTSW = 4'd10;
    localparam logic [3:0] OPCVTWS = 4'd11;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        accept, capture;
    logic        op_cmp, op_res_only, op_full, op_illegal;

    function automatic logic [4:0] lat_of(input logic [3:0] op);
        case (op)
            OPADDS, OPSUBS:   lat_of = 5'(LAT_ADDSUB);
            OPMULS:           lat_of = 5'(LAT_MUL);
            OPDIVS:           lat_of = 5'(LAT_DIV);
            OPSQRT:           lat_of = 5'(LAT_SQRT);
            OPCEQ, OPCLT, OPCLE: lat_of = 5'(LAT_CMP);
            OPCVTSW, OPCVTWS: lat_of = 5'(LAT_CVT);
            OPABS, OPNEG:     lat_of = 5'(LAT_COMB);
            default:          lat_of = 5'd0;
        endcase
    endfunction

    // Capture rules are decoded from the held op, which stays valid through the DONE cycle.
    assign op_cmp      = ofpu_control inside {OPCEQ, OPCLT, OPCLE};
    assign op_res_only = ofpu_control inside {OPNEG, OPCVTSW};
    assign op_full     = ofpu_control inside {OPADDS, OPSUBS, OPMULS, OPDIVS, OPSQRT, OPABS, OPCVTWS};
    assign op_illegal  = ofpu_control > OPCVTWS;

    assign accept   = istart && state != WAIT;
    assign capture  = state == WAIT && cnt == 5'd0;
    assign obusy    = state == WAIT;
    assign odone    = state == DONE;
    assign oillegal = odone && op_illegal;

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        state_nx = accept ? WAIT : capture ? DONE : obusy ? WAIT : IDLE;
    end

    always_ff @(posedge iclock or posedge ireset) begin
        if (ireset) begin
            cnt          <= '0;
            ofpu_control <= '0;
            ofpu_dataa   <= '0;
            ofpu_datab   <= '0;
            oresult      <= '0;
            onan         <= 1'b0;
            ozero        <= 1'b0;
            ooverflow    <= 1'b0;
            ounderflow   <= 1'b0;
            ocompresult  <= 1'b0;
        end else begin
            if (accept) begin
                ofpu_control <= iop;
                ofpu_dataa   <= ia;
                ofpu_datab   <= ib;
                cnt          <= lat_of(iop);
            end else if (obusy && cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
            if (capture) begin
                oresult     <= (op_full || op_res_only) ? ifpu_result : 32'd0;
                onan        <= op_full && ifpu_nan;
                ozero       <= op_full && ifpu_zero;
                ooverflow   <= op_full && ifpu_overflow;
                ounderflow  <= op_full && ifpu_underflow;
                ocompresult <= op_cmp && ifpu_compresult;
            end
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized and directed checks of fpu_issue_ctrl against a latency-table reference and a modelled FP ALU.
module tb_fpu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        istart = 1'b0;
    logic [3:0]  iop = '0;
    logic [31:0] ia = '0, ib = '0;
    logic        obusy, odone, oillegal, onan, ozero, ooverflow, ounderflow, ocompresult;
    logic [31:0] oresult, ofpu_dataa, ofpu_datab;
    logic [3:0]  ofpu_control;
    logic [31:0] ifpu_result = '0;
    logic        ifpu_nan = 0, ifpu_zero = 0, ifpu_overflow = 0, ifpu_underflow = 0, ifpu_compresult = 0;

    int tests = 0;
    int fails = 0;
    int lat_tab[16] = '{7, 7, 5, 6, 16, 0, 0, 1, 1, 1, 6, 6, 0, 0, 0, 0};

    // FP ALU model: correct outputs only once the op has been held for its latency, noise before.
    int          age = 0;
    int          cur_lat = 0;
    logic [31:0] alu_res = '0;
    logic [4:0]  alu_fl = '0;

    always #5 clk = ~clk;

    fpu_issue_ctrl dut (
        .iclock(clk), .ireset(rst), .istart(istart), .iop(iop), .ia(ia), .ib(ib),
        .obusy(obusy), .odone(odone), .oillegal(oillegal), .oresult(oresult),
        .onan(onan), .ozero(ozero), .ooverflow(ooverflow), .ounderflow(ounderflow),
        .ocompresult(ocompresult), .ofpu_control(ofpu_control),
        .ofpu_dataa(ofpu_dataa), .ofpu_datab(ofpu_datab),
        .ifpu_result(ifpu_result), .ifpu_nan(ifpu_nan), .ifpu_zero(ifpu_zero),
        .ifpu_overflow(ifpu_overflow), .ifpu_underflow(ifpu_underflow),
        .ifpu_compresult(ifpu_compresult)
    );

    always @(posedge clk) age <= (istart && !obusy && !rst) ? 0 : age + 1;

    always @(negedge clk) begin
        if (age >= cur_lat) begin
            ifpu_result = alu_res;
            {ifpu_nan, ifpu_zero, ifpu_overflow, ifpu_underflow, ifpu_compresult} = alu_fl;
        end else begin
            ifpu_result = $urandom;
            {ifpu_nan, ifpu_zero, ifpu_overflow, ifpu_underflow, ifpu_compresult} = 5'($urandom);
        end
    end

    function automatic logic [37:0] obs();
        return {oresult, onan, ozero, ooverflow, ounderflow, ocompresult, oillegal};
    endfunction

    // Expected {result, nan, zero, ovf, unf, comp, illegal} from the op class and what the ALU produced.
    function automatic logic [37:0] ref_out(input logic [3:0] op, input logic [31:0] res, input logic [4:0] fl);
        if (op > 4'd11) return {32'd0, 5'd0, 1'b1};
        if (op inside {4'd7, 4'd8, 4'd9}) return {32'd0, 4'd0, fl[0], 1'b0};
        if (op inside {4'd6, 4'd10}) return {res, 6'd0};
        return {res, fl[4:1], 2'b00};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, res, input logic [4:0] fl);
        @(negedge clk);
        iop = op; ia = a; ib = b; istart = 1'b1;
        cur_lat = lat_tab[op]; alu_res = res; alu_fl = fl;
        @(posedge clk);
        #1 istart = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!odone && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({obusy, odone, obs(), ofpu_control, ofpu_dataa, ofpu_datab} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b out=%h ctl=%h a=%h b=%h, required all zero",
                     obusy, odone, obs(), ofpu_control, ofpu_dataa, ofpu_datab);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_directed();
        int n;
        issue(4'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 5'd0);
        wait_done(1, n);
        tests++;
        if (n !== 9 || obs() !== {32'h40400000, 6'd0}) begin
            fails++;
            $display("FAIL adds: clks=%0d out=%h, required clks=9 out=%h", n, obs(), {32'h40400000, 6'd0});
        end
        issue(4'd8, 32'h3F800000, 32'h40000000, 32'hDEADBEEF, 5'b00001);
        wait_done(1, n);
        tests++;
        if (n !== 3 || obs() !== {32'd0, 4'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL clt: clks=%0d out=%h, required clks=3 comp=1 result=0", n, obs());
        end
        issue(4'd4, 32'hBF800000, 32'h0, 32'h7FC00000, 5'b10000);
        wait_done(1, n);
        tests++;
        if (n !== 18 || onan !== 1'b1 || oresult !== 32'h7FC00000) begin
            fails++;
            $display("FAIL sqrt_neg: clks=%0d nan=%b result=%h, required clks=18 nan=1 result=7fc00000", n, onan, oresult);
        end
    endtask

    task automatic test_ignore_start();
        int n, pulses;
        issue(4'd0, 32'h11111111, 32'h22222222, 32'h33333333, 5'b01110);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        istart = 1'b1; iop = 4'd2; ia = 32'hAAAAAAAA; ib = 32'h55555555;
        @(posedge clk);
        #1 istart = 1'b0;
        tests++;
        if ({ofpu_control, ofpu_dataa, ofpu_datab} !== {4'd0, 32'h11111111, 32'h22222222} || obusy !== 1'b1) begin
            fails++;
            $display("FAIL ignore_start_hold: ctl=%h a=%h b=%h busy=%b, required 0/11111111/22222222 busy=1",
                     ofpu_control, ofpu_dataa, ofpu_datab, obusy);
        end
        wait_done(4, n);
        tests++;
        if (n !== 9 || obs() !== ref_out(4'd0, 32'h33333333, 5'b01110)) begin
            fails++;
            $display("FAIL ignore_start_done: clks=%0d out=%h, required clks=9 out=%h", n, obs(), ref_out(4'd0, 32'h33333333, 5'b01110));
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1 pulses += int'(odone) + int'(obusy);
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL ignore_start_single: extra busy/done cycles=%0d, required 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int n, pulses;
        issue(4'd1, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 5'b11111);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({obusy, odone, obs(), ofpu_control, ofpu_dataa, ofpu_datab} !== '0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b out=%h ctl=%h a=%h b=%h, required all zero",
                     obusy, odone, obs(), ofpu_control, ofpu_dataa, ofpu_datab);
        end
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1 pulses += int'(odone);
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: done pulses=%0d, required 0", pulses);
        end
        issue(4'd2, 32'h40000000, 32'h40000000, 32'h40800000, 5'd0);
        wait_done(1, n);
        tests++;
        if (n !== 7 || obs() !== {32'h40800000, 6'd0}) begin
            fails++;
            $display("FAIL reset_mid_restart: clks=%0d out=%h, required clks=7 result=40800000", n, obs());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'hF, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 5'b11111);
        wait_done(1, n);
        tests++;
        if (n !== 2 || obs() !== {32'd0, 5'd0, 1'b1}) begin
            fails++;
            $display("FAIL illegal: clks=%0d out=%h, required clks=2 illegal=1 rest 0", n, obs());
        end
        issue(4'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'd0);
        tests++;
        if (obusy !== 1'b1 || ofpu_control !== 4'd0 || ofpu_dataa !== 32'h3F800000) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b ctl=%h a=%h, required busy=1 ctl=0 a=3f800000", obusy, ofpu_control, ofpu_dataa);
        end
        wait_done(1, n);
        tests++;
        if (n !== 9 || obs() !== {32'h40000000, 6'd0}) begin
            fails++;
            $display("FAIL b2b_done: clks=%0d out=%h, required clks=9 result=40000000", n, obs());
        end
    endtask

    task automatic test_random();
        int n;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  fl;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom); a = $urandom; b = $urandom; res = $urandom; fl = 5'($urandom);
            issue(op, a, b, res, fl);
            tests++;
            if ({obusy, ofpu_control, ofpu_dataa, ofpu_datab} !== {1'b1, op, a, b}) begin
                fails++;
                $display("FAIL rand_issue[%0d]: busy=%b ctl=%h a=%h b=%h, required 1/%h/%h/%h",
                         i, obusy, ofpu_control, ofpu_dataa, ofpu_datab, op, a, b);
            end
            wait_done(1, n);
            tests++;
            if (n !== lat_tab[op] + 2 || obs() !== ref_out(op, res, fl)) begin
                fails++;
                $display("FAIL rand_done[%0d] op=%h: clks=%0d out=%h, required clks=%0d out=%h",
                         i, op, n, obs(), lat_tab[op] + 2, ref_out(op, res, fl));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
